// File: rtl/est_output_serial_mk.sv
// Serial Z = H*x with one signed MAC per clock, N-bit saturating results; define EST_OUTPUT_ROUND_EN for round-half-up.
// Latency M*K+1 cycles from start to done; start is ignored while busy or done (no queuing).
module est_output_serial_mk #(
   parameter int N    = 20,
   parameter int FRAC = 10,
   parameter int M    = 2,
   parameter int K    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [M*K*N-1:0]   h_flat,
   input  logic [K*N-1:0]     x_flat,
   output logic               busy,
   output logic               done,
   output logic [M*N-1:0]     z_flat
);

   localparam int AW = 2*N + $clog2(K) + 1;
   localparam int RW = (M   > 1) ? $clog2(M)   : 1;
   localparam int CW = (K   > 1) ? $clog2(K)   : 1;
   localparam int HW = (M*K > 1) ? $clog2(M*K) : 1;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef EST_OUTPUT_ROUND_EN
   // Half an LSB preloaded per row turns the floor shift into round-half-up.
   localparam logic signed [AW-1:0] ACC_INIT = {{(AW-1){1'b0}}, 1'b1} << (FRAC-1);
`else
   localparam logic signed [AW-1:0] ACC_INIT = '0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic signed [N-1:0]    h_r    [M*K];
   logic signed [N-1:0]    x_r    [K];
   logic signed [N-1:0]    rowbuf [M];
   logic signed [AW-1:0]   acc;
   logic [RW-1:0]          row;
   logic [CW-1:0]          col;
   logic [HW-1:0]          hidx;

   logic signed [2*N-1:0]  prod;
   logic signed [AW-1:0]   prod_ext;
   logic signed [AW-1:0]   sum;
   logic signed [AW-1:0]   shifted;
   logic signed [N-1:0]    row_sat;
   logic                   col_last;
   logic                   last_mac;
   logic [M*N-1:0]         z_next;

   assign prod     = h_r[hidx] * x_r[col];
   assign prod_ext = {{(AW-2*N){prod[2*N-1]}}, prod};
   assign sum      = acc + prod_ext;
   assign shifted  = sum >>> FRAC;
   assign col_last = (col == CW'(K-1));
   assign last_mac = (state == S_MAC) && col_last && (row == RW'(M-1));

   always_comb begin
      row_sat = shifted[N-1:0];
      if (shifted > SAT_MAX) begin
         row_sat = SAT_MAX[N-1:0];
      end else if (shifted < SAT_MIN) begin
         row_sat = SAT_MIN[N-1:0];
      end
   end

   // The final row is still in flight on the last MAC edge, so it bypasses the buffer.
   always_comb begin
      z_next = '0;
      for (int i = 0; i < M; i++) begin
         z_next[i*N +: N] = (i == M-1) ? row_sat : rowbuf[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_MAC;
            end
         end
         S_MAC: begin
            busy = 1'b1;
            if (last_mac) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         row    <= '0;
         col    <= '0;
         hidx   <= '0;
         z_flat <= '0;
         for (int i = 0; i < M*K; i++) h_r[i]    <= '0;
         for (int j = 0; j < K; j++)   x_r[j]    <= '0;
         for (int i = 0; i < M; i++)   rowbuf[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < M*K; i++) h_r[i] <= h_flat[i*N +: N];
                  for (int j = 0; j < K; j++)   x_r[j] <= x_flat[j*N +: N];
                  acc  <= ACC_INIT;
                  row  <= '0;
                  col  <= '0;
                  hidx <= '0;
               end
            end
            S_MAC: begin
               hidx <= hidx + 1'b1;
               if (col_last) begin
                  rowbuf[row] <= row_sat;
                  acc         <= ACC_INIT;
                  col         <= '0;
                  row         <= row + 1'b1;
                  if (last_mac) begin
                     z_flat <= z_next;
                  end
               end else begin
                  acc <= sum;
                  col <= col + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_est_output_serial_mk.sv
// Bench for est_output_serial_mk: 2x2 and 3x2 instances, table vectors, random ops vs. an arithmetic model.
module tb_est_output_serial_mk;

   localparam int S = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [79:0]   h_flat = '0;
   logic [39:0]   x_flat = '0;
   logic          busy, done;
   logic [39:0]   z_flat;

   logic          start3 = 1'b0;
   logic [119:0]  h3_flat = '0;
   logic [39:0]   x3_flat = '0;
   logic          busy3, done3;
   logic [59:0]   z3_flat;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   est_output_serial_mk #(.N(20), .FRAC(10), .M(2), .K(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .h_flat(h_flat), .x_flat(x_flat),
      .busy(busy), .done(done), .z_flat(z_flat));

   est_output_serial_mk #(.N(20), .FRAC(10), .M(3), .K(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .h_flat(h3_flat), .x_flat(x3_flat),
      .busy(busy3), .done(done3), .z_flat(z3_flat));

   typedef struct {
      int h0, h1, h2, h3;
      int x0, x1;
      int z0, z1;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Row result from the exact dot product: optional half-LSB, floor shift, clamp.
   function automatic int model_z(input longint s);
      longint r;
`ifdef EST_OUTPUT_ROUND_EN
      s = s + longint'(S/2);
`endif
      r = s >>> 10;
      if (r > 524287) r = 524287;
      else if (r < -524288) r = -524288;
      return int'(r);
   endfunction

   function automatic logic [79:0] pack_h(input int a, input int b, input int c, input int d);
      logic [79:0] f;
      f[19:0] = a[19:0]; f[39:20] = b[19:0]; f[59:40] = c[19:0]; f[79:60] = d[19:0];
      return f;
   endfunction

   function automatic logic [39:0] pack_x(input int a, input int b);
      logic [39:0] f;
      f[19:0] = a[19:0]; f[39:20] = b[19:0];
      return f;
   endfunction

   function automatic int rand_word();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4095)) - 2048;
      return int'($urandom_range(0, 1048575)) - 524288;
   endfunction

   // Called at a negedge with the DUT idle (or in the cycle after done); returns one cycle after done.
   task automatic run2(input logic [79:0] hf, input logic [39:0] xf,
                       output int lat, output int busy_cnt, output int z0, output int z1);
      lat = -1; busy_cnt = 0; z0 = 0; z1 = 0;
      start = 1'b1; h_flat = hf; x_flat = xf;
      @(posedge clk); @(negedge clk);
      start = 1'b0; h_flat = {$urandom, $urandom, $urandom}; x_flat = {$urandom, $urandom};
      for (int c = 0; c <= 20; c++) begin
         if (busy) busy_cnt++;
         if (busy && done) check("busy_done_overlap", 1, 0);
         if (done) begin
            lat = c;
            z0 = int'($signed(z_flat[19:0]));
            z1 = int'($signed(z_flat[39:20]));
            break;
         end
         @(posedge clk); @(negedge clk);
      end
      if (lat >= 0) begin
         @(posedge clk); @(negedge clk);
         check("done_one_cycle", longint'(done), 0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      int lat, bc, z0, z1, dcnt, zc0, zc1;
      longint s0, s1;
      vec_t v;

      vecs[0] = '{S, 0, 0, S, 1536, -768, 1536, -768};
      vecs[1] = '{400*S, 400*S, 400*S, 400*S, 400*S, 400*S, 524287, 524287};
      vecs[2] = '{400*S, 400*S, 400*S, 400*S, -400*S, -400*S, -524288, -524288};
`ifdef EST_OUTPUT_ROUND_EN
      vecs[3] = '{S/2, 0, S/2, 0, 3, -3, 2, 2};
      vecs[4] = '{S/2, 0, S/2, 0, -3, 0, -1, -1};
`else
      vecs[3] = '{S/2, 0, S/2, 0, 3, -3, 1, 1};
      vecs[4] = '{S/2, 0, S/2, 0, -3, 0, -2, -2};
`endif
      vecs[5] = '{2*S, -S, S/4, 3*S, -5*S, S, -11*S, -5*S/4 + 3*S};

      repeat (3) @(negedge clk);
      check("reset_busy", longint'(busy), 0);
      check("reset_done", longint'(done), 0);
      check("reset_z", longint'(z_flat), 0);
      check("reset_z3", longint'(z3_flat), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         run2(pack_h(v.h0, v.h1, v.h2, v.h3), pack_x(v.x0, v.x1), lat, bc, z0, z1);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_busy_cycles", i), bc, 4);
         check($sformatf("vec%0d_z0", i), z0, v.z0);
         check($sformatf("vec%0d_z1", i), z1, v.z1);
      end

      // General 3x2 on the M=3 instance.
      start3 = 1'b1;
      h3_flat = {20'(3*S), 20'(0), 20'(S/2), 20'(-S), 20'(2*S), 20'(S)};
      x3_flat = {20'(-S), 20'(S)};
      @(posedge clk); @(negedge clk);
      start3 = 1'b0; x3_flat = '0;
      lat = -1;
      for (int c = 0; c <= 20; c++) begin
         if (done3) begin lat = c; break; end
         @(posedge clk); @(negedge clk);
      end
      check("m3_latency", lat, 6);
      check("m3_z0", int'($signed(z3_flat[19:0])), -1024);
      check("m3_z1", int'($signed(z3_flat[39:20])), -1536);
      check("m3_z2", int'($signed(z3_flat[59:40])), -3072);
      @(posedge clk); @(negedge clk);

      // Start while busy: second pulse two cycles later must be ignored.
      start = 1'b1; h_flat = pack_h(S, 0, 0, S); x_flat = pack_x(100*S, -7*S);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      start = 1'b1; x_flat = pack_x(5*S, 9*S);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      dcnt = 0; zc0 = 0; zc1 = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) begin
            dcnt++;
            zc0 = int'($signed(z_flat[19:0]));
            zc1 = int'($signed(z_flat[39:20]));
         end
         @(posedge clk); @(negedge clk);
      end
      check("busy_start_done_count", dcnt, 1);
      check("busy_start_z0", zc0, 100*S);
      check("busy_start_z1", zc1, -7*S);

      // Back-to-back: second op begins in the cycle right after done.
      run2(pack_h(S, 0, 0, S), pack_x(3*S, 4*S), lat, bc, z0, z1);
      run2(pack_h(0, S, S, 0), pack_x(3*S, 4*S), lat, bc, z0, z1);
      check("b2b_latency", lat, 4);
      check("b2b_z0", z0, 4*S);
      check("b2b_z1", z1, 3*S);

      // Reset two cycles into an operation.
      start = 1'b1; h_flat = pack_h(S, S, S, S); x_flat = pack_x(S, S);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", longint'(busy), 0);
      check("rst_mid_done", longint'(done), 0);
      check("rst_mid_z", longint'(z_flat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_after_z", longint'(z_flat), 0);
      run2(pack_h(S, 0, 0, S), pack_x(1536, -768), lat, bc, z0, z1);
      check("post_rst_latency", lat, 4);
      check("post_rst_busy_cycles", bc, 4);
      check("post_rst_z0", z0, 1536);
      check("post_rst_z1", z1, -768);

      for (int i = 0; i < 40; i++) begin
         v.h0 = rand_word(); v.h1 = rand_word(); v.h2 = rand_word(); v.h3 = rand_word();
         v.x0 = rand_word(); v.x1 = rand_word();
         s0 = longint'(v.h0) * v.x0 + longint'(v.h1) * v.x1;
         s1 = longint'(v.h2) * v.x0 + longint'(v.h3) * v.x1;
         run2(pack_h(v.h0, v.h1, v.h2, v.h3), pack_x(v.x0, v.x1), lat, bc, z0, z1);
         check($sformatf("rand%0d_latency", i), lat, 4);
         check($sformatf("rand%0d_z0", i), z0, model_z(s0));
         check($sformatf("rand%0d_z1", i), z1, model_z(s1));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
